// File: rtl/udp_gmii_rx_framer.sv
// GMII receive framer: removes preamble/SFD, forwards frame bytes with one cycle
// of latency and reports CRC, length and rx_er status on a one-cycle end-of-frame strobe.
module udp_gmii_rx_framer #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int MAX_PREAMBLE  = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_good,
  output logic [10:0] frame_len
);

  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  PREAMBLE = 2'd1;
  localparam logic [1:0]  DATA     = 2'd2;
  localparam logic [1:0]  DROP     = 2'd3;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] LEN_MIN     = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] LEN_MAX     = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] LEN_SAT     = 11'd2047;
  localparam logic [7:0]  PRE_MAX     = 8'(MAX_PREAMBLE);
  localparam logic [7:0]  BYTE_PRE    = 8'h55;
  localparam logic [7:0]  BYTE_SFD    = 8'hD5;

  logic [1:0]  r_state;
  logic [7:0]  r_preCnt;
  logic [31:0] r_crc;
  logic [10:0] r_len;
  logic        r_err;
  logic        r_first;
  logic        r_dvPrev;
  logic [7:0]  r_outData;
  logic        r_outValid;
  logic        r_outSof;
  logic        r_outEof;
  logic        r_frameGood;

  logic [31:0] w_crcNext;
  logic        w_lenOk;

  function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign w_crcNext = crcByte(r_crc, gmii_rxd);
  assign w_lenOk   = (r_len >= LEN_MIN) && (r_len <= LEN_MAX);

  // r_dvPrev resets high so a stream still running when reset releases is
  // never mistaken for a fresh preamble; only a rising rx_dv may start a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_preCnt    <= 8'd0;
      r_crc       <= CRC_INIT;
      r_len       <= 11'd0;
      r_err       <= 1'b0;
      r_first     <= 1'b0;
      r_dvPrev    <= 1'b1;
      r_outData   <= 8'h00;
      r_outValid  <= 1'b0;
      r_outSof    <= 1'b0;
      r_outEof    <= 1'b0;
      r_frameGood <= 1'b0;
    end else begin
      r_dvPrev    <= gmii_rx_dv;
      r_outValid  <= 1'b0;
      r_outSof    <= 1'b0;
      r_outEof    <= 1'b0;
      r_frameGood <= 1'b0;
      case (r_state)
        IDLE: begin
          if (gmii_rx_dv) begin
            if (!r_dvPrev && !gmii_rx_er && gmii_rxd == BYTE_PRE) begin
              r_state  <= PREAMBLE;
              r_preCnt <= 8'd1;
            end else begin
              r_state <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!gmii_rx_dv) begin
            r_state <= IDLE;
          end else if (gmii_rx_er) begin
            r_state <= DROP;
          end else if (gmii_rxd == BYTE_PRE) begin
            if (r_preCnt >= PRE_MAX) begin
              r_state <= DROP;
            end else begin
              r_preCnt <= r_preCnt + 8'd1;
            end
          end else if (gmii_rxd == BYTE_SFD) begin
            r_state <= DATA;
            r_crc   <= CRC_INIT;
            r_len   <= 11'd0;
            r_err   <= 1'b0;
            r_first <= 1'b1;
          end else begin
            r_state <= DROP;
          end
        end
        DATA: begin
          if (gmii_rx_dv) begin
            r_outData  <= gmii_rxd;
            r_outValid <= 1'b1;
            r_outSof   <= r_first;
            r_first    <= 1'b0;
            r_crc      <= w_crcNext;
            if (r_len != LEN_SAT) begin
              r_len <= r_len + 11'd1;
            end
            if (gmii_rx_er) begin
              r_err <= 1'b1;
            end
          end else begin
            r_outEof    <= 1'b1;
            r_frameGood <= (r_crc == CRC_RESIDUE) && !r_err && w_lenOk;
            r_state     <= IDLE;
          end
        end
        default: begin
          if (!gmii_rx_dv) begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign out_data   = r_outData;
  assign out_valid  = r_outValid;
  assign out_sof    = r_outSof;
  assign out_eof    = r_outEof;
  assign frame_good = r_frameGood;
  assign frame_len  = r_len;

endmodule

// File: tb/tb_udp_gmii_rx_framer.sv
// Randomized self-checking bench for udp_gmii_rx_framer: frames are built with a
// proper Ethernet FCS and every output is compared with what the frame rules predict.
module tb_udp_gmii_rx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        frame_good;
  logic [10:0] frame_len;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  byte unsigned frameQ[$];
  byte unsigned expQ[$];
  byte unsigned rxQ[$];
  int           sofCycQ[$];
  int           sofPosQ[$];
  int           eofCycQ[$];
  int           eofGapQ[$];
  int           lenQ[$];
  bit           goodQ[$];
  int           lastValidCyc;
  int           overlapCount;
  int           straySof;

  udp_gmii_rx_framer dut (
    .clk        (clk),
    .rst        (rst),
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .frame_good (frame_good),
    .frame_len  (frame_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are sampled on the falling edge, half a cycle away from the DUT's edge.
  always @(negedge clk) begin
    if (out_valid) begin
      if (out_sof) begin
        sofCycQ.push_back(cyc);
        sofPosQ.push_back(rxQ.size());
      end
      rxQ.push_back(out_data);
      lastValidCyc = cyc;
      if (out_eof) overlapCount++;
    end else if (out_sof) begin
      straySof++;
    end
    if (out_eof) begin
      eofCycQ.push_back(cyc);
      eofGapQ.push_back(cyc - lastValidCyc);
      goodQ.push_back(frame_good);
      lenQ.push_back(int'(frame_len));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_monitor();
    frameQ.delete(); expQ.delete(); rxQ.delete();
    sofCycQ.delete(); sofPosQ.delete(); eofCycQ.delete(); eofGapQ.delete();
    lenQ.delete(); goodQ.delete();
    lastValidCyc = 0; overlapCount = 0; straySof = 0;
  endtask

  // Payload is random; FCS is the complemented reflected CRC-32 sent LSB first.
  task automatic build_frame(input int totalLen, input bit corrupt);
    logic [31:0] crc;
    logic [31:0] fcs;
    byte unsigned b;
    frameQ.delete();
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < totalLen - 4; i++) begin
      b = byte'($urandom_range(0, 255));
      frameQ.push_back(b);
      crc = crc ^ {24'h0, b};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) begin
      frameQ.push_back(fcs[7:0]);
      fcs = fcs >> 8;
    end
    if (corrupt) frameQ[frameQ.size() - 1] = frameQ[frameQ.size() - 1] ^ 8'h01;
    foreach (frameQ[i]) expQ.push_back(frameQ[i]);
  endtask

  task automatic drive_byte(input bit dv, input bit er, input logic [7:0] d);
    @(posedge clk);
    #1;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    gmii_rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_byte(1'b0, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  task automatic send_frame(input int preLen, input int erIdx);
    for (int i = 0; i < preLen; i++) drive_byte(1'b1, 1'b0, 8'h55);
    drive_byte(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < frameQ.size(); i++) drive_byte(1'b1, i == erIdx, frameQ[i]);
  endtask

  function automatic int dataErrors();
    int e;
    int n;
    e = 0;
    n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
    for (int i = 0; i < n; i++) if (rxQ[i] != expQ[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({out_valid, out_sof, out_eof, frame_good} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {out_valid, out_sof, out_eof, frame_good});
    end
    compared++;
    if (frame_len !== 11'd0 || out_data !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_data_len: got len=%0d data=%h expected len=0 data=00", frame_len, out_data);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frames();
    int lens[3];
    int pre;
    lens = '{64, int'($urandom_range(65, 300)), int'($urandom_range(65, 300))};
    for (int t = 0; t < 3; t++) begin
      clear_monitor();
      pre = (t == 0) ? 7 : int'($urandom_range(1, 7));
      build_frame(lens[t], 1'b0);
      send_frame(pre, -1);
      idle(4);
      compared++;
      if (rxQ.size() != expQ.size()) begin
        mismatched++;
        $display("[TB] FAIL good_count[%0d]: got %0d bytes expected %0d", t, rxQ.size(), expQ.size());
      end
      compared++;
      if (dataErrors() != 0) begin
        mismatched++;
        $display("[TB] FAIL good_data[%0d]: got %0d wrong bytes expected 0", t, dataErrors());
      end
      compared++;
      if (sofPosQ.size() != 1 || sofPosQ[0] != 0 || straySof != 0) begin
        mismatched++;
        $display("[TB] FAIL good_sof[%0d]: got %0d sofs (stray %0d) expected one on byte 0", t, sofPosQ.size(), straySof);
      end
      compared++;
      if (eofGapQ.size() != 1 || eofGapQ[0] != 1 || overlapCount != 0) begin
        mismatched++;
        $display("[TB] FAIL good_eof[%0d]: got %0d eofs overlap %0d expected one eof one cycle after last byte", t, eofGapQ.size(), overlapCount);
      end
      compared++;
      if (goodQ.size() != 1 || goodQ[0] !== 1'b1 || lenQ[0] != lens[t]) begin
        mismatched++;
        $display("[TB] FAIL good_status[%0d]: got good=%0d len=%0d expected good=1 len=%0d", t,
                 (goodQ.size() > 0) ? int'(goodQ[0]) : -1, (lenQ.size() > 0) ? lenQ[0] : -1, lens[t]);
      end
    end
  endtask

  task automatic test_bad_fcs();
    clear_monitor();
    build_frame(64, 1'b1);
    send_frame(7, -1);
    idle(4);
    compared++;
    if (rxQ.size() != 64 || dataErrors() != 0) begin
      mismatched++;
      $display("[TB] FAIL badfcs_data: got %0d bytes %0d wrong expected 64 bytes 0 wrong", rxQ.size(), dataErrors());
    end
    compared++;
    if (goodQ.size() != 1 || goodQ[0] !== 1'b0 || lenQ[0] != 64) begin
      mismatched++;
      $display("[TB] FAIL badfcs_status: got %0d eofs good=%0d expected one eof good=0 len=64",
               goodQ.size(), (goodQ.size() > 0) ? int'(goodQ[0]) : -1);
    end
  endtask

  task automatic test_rx_error();
    clear_monitor();
    build_frame(64, 1'b0);
    send_frame(7, 20);
    idle(4);
    compared++;
    if (rxQ.size() != 64 || goodQ.size() != 1 || goodQ[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rxer_frame: got %0d bytes %0d eofs expected 64 bytes and good=0", rxQ.size(), goodQ.size());
    end
    clear_monitor();
    build_frame(64, 1'b0);
    send_frame(7, -1);
    idle(4);
    compared++;
    if (goodQ.size() != 1 || goodQ[0] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rxer_recover: got %0d eofs expected one eof with good=1", goodQ.size());
    end
  endtask

  task automatic test_preamble_errors();
    for (int c = 0; c < 4; c++) begin
      clear_monitor();
      build_frame(64, 1'b0);
      case (c)
        0: begin
          drive_byte(1'b1, 1'b0, 8'h55);
          drive_byte(1'b1, 1'b0, 8'h55);
          drive_byte(1'b1, 1'b0, 8'h5D);
          for (int i = 0; i < 10; i++) drive_byte(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        end
        1: send_frame(0, -1);
        2: send_frame(8, -1);
        default: begin
          drive_byte(1'b1, 1'b0, 8'h55);
          drive_byte(1'b1, 1'b0, 8'h55);
          drive_byte(1'b1, 1'b1, 8'h55);
          send_frame(2, -1);
        end
      endcase
      idle(4);
      compared++;
      if (rxQ.size() != 0 || eofCycQ.size() != 0 || straySof != 0) begin
        mismatched++;
        $display("[TB] FAIL preamble_drop[%0d]: got %0d bytes %0d eofs expected none", c, rxQ.size(), eofCycQ.size());
      end
    end
    clear_monitor();
    build_frame(64, 1'b0);
    send_frame(7, -1);
    idle(4);
    compared++;
    if (rxQ.size() != 64 || goodQ.size() != 1 || goodQ[0] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL preamble_recover: got %0d bytes %0d eofs expected 64 bytes good=1", rxQ.size(), goodQ.size());
    end
  endtask

  task automatic test_length_limits();
    int lens[6];
    bit expGood;
    lens = '{40, 1600, 63, 64, 1518, 1519};
    for (int t = 0; t < 6; t++) begin
      clear_monitor();
      build_frame(lens[t], 1'b0);
      send_frame(7, -1);
      idle(4);
      expGood = (lens[t] >= 64) && (lens[t] <= 1518);
      compared++;
      if (goodQ.size() != 1 || goodQ[0] !== expGood || lenQ[0] != lens[t] || rxQ.size() != lens[t]) begin
        mismatched++;
        $display("[TB] FAIL length[%0d]: got %0d eofs good=%0d len=%0d bytes=%0d expected good=%0d len=%0d", t,
                 goodQ.size(), (goodQ.size() > 0) ? int'(goodQ[0]) : -1,
                 (lenQ.size() > 0) ? lenQ[0] : -1, rxQ.size(), expGood, lens[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lenA;
    int lenB;
    clear_monitor();
    lenA = int'($urandom_range(64, 128));
    lenB = int'($urandom_range(64, 128));
    build_frame(lenA, 1'b0);
    send_frame(7, -1);
    idle(1);
    build_frame(lenB, 1'b0);
    send_frame(7, -1);
    idle(4);
    compared++;
    if (rxQ.size() != lenA + lenB || dataErrors() != 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_data: got %0d bytes %0d wrong expected %0d bytes", rxQ.size(), dataErrors(), lenA + lenB);
    end
    compared++;
    if (eofCycQ.size() != 2 || sofCycQ.size() != 2 || eofCycQ[0] >= sofCycQ[1] || sofPosQ[1] != lenA) begin
      mismatched++;
      $display("[TB] FAIL b2b_order: got %0d eofs %0d sofs expected 2 each with eof0 before sof1", eofCycQ.size(), sofCycQ.size());
    end
    compared++;
    if (goodQ.size() != 2 || goodQ[0] !== 1'b1 || goodQ[1] !== 1'b1 || lenQ[0] != lenA || lenQ[1] != lenB) begin
      mismatched++;
      $display("[TB] FAIL b2b_status: got %0d eofs expected two good frames of %0d and %0d", goodQ.size(), lenA, lenB);
    end
  endtask

  task automatic test_reset_midframe();
    int savedSize;
    clear_monitor();
    build_frame(64, 1'b0);
    for (int i = 0; i < 7; i++) drive_byte(1'b1, 1'b0, 8'h55);
    drive_byte(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 30; i++) drive_byte(1'b1, 1'b0, frameQ[i]);
    @(posedge clk);
    #1;
    rst = 1'b1;
    gmii_rxd = frameQ[30];
    #1;
    compared++;
    if ({out_valid, out_sof, out_eof, frame_good} !== 4'b0000 || out_data !== 8'h00 || frame_len !== 11'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: got flags=%b data=%h len=%0d expected all zero",
               {out_valid, out_sof, out_eof, frame_good}, out_data, frame_len);
    end
    savedSize = rxQ.size();
    @(posedge clk);
    #1;
    rst = 1'b0;
    gmii_rxd = frameQ[31];
    for (int i = 32; i < 64; i++) drive_byte(1'b1, 1'b0, frameQ[i]);
    idle(4);
    compared++;
    if (rxQ.size() != savedSize || eofCycQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL midreset_drop: got %0d bytes %0d eofs expected %0d bytes 0 eofs", rxQ.size(), eofCycQ.size(), savedSize);
    end
    clear_monitor();
    build_frame(64, 1'b0);
    send_frame(7, -1);
    idle(4);
    compared++;
    if (rxQ.size() != 64 || goodQ.size() != 1 || goodQ[0] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midreset_recover: got %0d bytes %0d eofs expected 64 bytes good=1", rxQ.size(), goodQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frames();
    test_bad_fcs();
    test_rx_error();
    test_preamble_errors();
    test_length_limits();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
